// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// fixed XLEN+1 cycle busy window with start/busy/done handshake and abort.
module alu_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      aluOpcode,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]        state_r;
  logic [2:0]        op_r;
  logic              sign_a_r;
  logic              sign_b_r;
  logic              b_zero_r;
  logic [XLEN-1:0]   opnd_r;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic [XLEN-1:0]   result_r;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;
  logic              done_r;

  logic              is_mop_s;
  logic              a_signed_s;
  logic              b_signed_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_trial_s;
  logic [XLEN-1:0]   step_hi_s;
  logic [XLEN-1:0]   step_lo_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   result_s;

  // Opcode decode and operand magnitudes; M-ops occupy 5'b10xxx, bit 2 selects divide.
  always_comb begin
    is_mop_s = (aluOpcode[4:3] == 2'b10);
    if (aluOpcode[2]) begin
      a_signed_s = ~aluOpcode[0];
      b_signed_s = ~aluOpcode[0];
    end else begin
      a_signed_s = (aluOpcode[1:0] != 2'b11);
      b_signed_s = ~aluOpcode[1];
    end
    a_neg_s = a_signed_s & operandA[XLEN-1];
    b_neg_s = b_signed_s & operandB[XLEN-1];
    if (a_neg_s) a_mag_s = -operandA;
    else         a_mag_s = operandA;
    if (b_neg_s) b_mag_s = -operandB;
    else         b_mag_s = operandB;
  end

  // One radix-2 step: {hi,lo} is the product for multiply, {remainder,quotient} for divide.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    div_trial_s = {hi_r, lo_r[XLEN-1]} - {1'b0, opnd_r};
    if (op_r[2]) begin
      if (!div_trial_s[XLEN]) begin
        step_hi_s = div_trial_s[XLEN-1:0];
        step_lo_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        step_hi_s = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
        step_lo_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi_s = mul_sum_s[XLEN:1];
      step_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign correction and output select; signed overflow falls out of the magnitude math.
  always_comb begin
    if (sign_a_r ^ sign_b_r) begin
      prod_fix_s = -{hi_r, lo_r};
      quo_fix_s  = -lo_r;
    end else begin
      prod_fix_s = {hi_r, lo_r};
      quo_fix_s  = lo_r;
    end
    if (sign_a_r) rem_fix_s = -hi_r;
    else          rem_fix_s = hi_r;
    if (!op_r[2]) begin
      if (op_r[1:0] == 2'b00) result_s = prod_fix_s[XLEN-1:0];
      else                    result_s = prod_fix_s[2*XLEN-1:XLEN];
    end else if (op_r[1]) begin
      result_s = rem_fix_s;
    end else if (b_zero_r) begin
      result_s = {XLEN{1'b1}};
    end else begin
      result_s = quo_fix_s;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      op_r     <= 3'd0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      b_zero_r <= 1'b0;
      opnd_r   <= {XLEN{1'b0}};
      hi_r     <= {XLEN{1'b0}};
      lo_r     <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && is_mop_s) begin
            op_r     <= aluOpcode[2:0];
            sign_a_r <= a_neg_s;
            sign_b_r <= b_neg_s;
            b_zero_r <= (operandB == {XLEN{1'b0}});
            hi_r     <= {XLEN{1'b0}};
            opnd_r   <= aluOpcode[2] ? b_mag_s : a_mag_s;
            lo_r     <= aluOpcode[2] ? a_mag_s : b_mag_s;
            cnt_r    <= CW'(XLEN);
            busy_r   <= 1'b1;
            state_r  <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (abort) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            hi_r  <= step_hi_s;
            lo_r  <= step_lo_s;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (!abort) begin
            result_r <= result_s;
            done_r   <= 1'b1;
          end
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed vector table, handshake corner
// sequences, and randomized operations against a plain-arithmetic reference model.
module tb_alu_muldiv_unit;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  aluOpcode;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int pass_cnt;
  int total_cnt;
  logic [31:0] last_res;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  alu_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluOpcode(aluOpcode),
    .operandA(operandA), .operandB(operandB), .abort(abort),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // RISC-V M semantics computed directly with 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      OP_MULHU:  begin up = ua * ub; return up[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REMU: begin
        if (b == 32'd0) return a;
        return a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Present a request so that it is sampled at the next rising edge; returns #1 after it.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    aluOpcode = op;
    operandA = a;
    operandB = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    operandA = $urandom;
    operandB = $urandom;
    aluOpcode = OP_ADD;
  endtask

  // Full operation: latency, busy window, done width and result; dbl_at injects a second start.
  task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int dbl_at);
    int lat;
    int busy_n;
    bit got;
    start_op(op, a, b);
    check({name, " done_low_at_accept"}, {63'd0, done}, 64'd0);
    busy_n = busy ? 1 : 0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (lat == dbl_at) begin
        start = 1'b1;
        aluOpcode = OP_DIVU;
        operandA = $urandom;
        operandB = 32'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " busy_cycles"}, 64'(busy_n), 64'd33);
    check({name, " result"}, {32'd0, result}, {32'd0, exp});
    last_res = exp;
  endtask

  initial begin
    int done_seen;
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    aluOpcode = OP_ADD;
    operandA = 32'd0;
    operandB = 32'd0;
    last_res = 32'd0;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE};
    vecs[6]  = '{OP_DIVU,   32'd20,         32'd3,         32'd6};
    vecs[7]  = '{OP_REMU,   32'd20,         32'd3,         32'd2};
    vecs[8]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{OP_REMU,   32'd5,          32'd0,         32'd5};
    vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};

    #22;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, -1);

    // Non-M opcode is ignored.
    start_op(OP_ADD, 32'd1, 32'd2);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy || done) done_seen++;
      @(posedge clk);
      #1;
    end
    check("add_ignored", 64'(done_seen), 64'd0);

    // Second start mid-operation is ignored.
    do_op("double_start", OP_MUL, 32'd12345, 32'd678, 32'd8369910, 10);

    // Abort at cycle 15: no done, result holds.
    start_op(OP_MUL, 32'd99, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort done", {63'd0, done}, 64'd0);
    check("abort result", {32'd0, result}, {32'd0, last_res});
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort no_done", 64'(done_seen), 64'd0);

    // abort held in IDLE does not block a simultaneous start.
    abort = 1'b1;
    do_op("abort_idle", OP_DIVU, 32'd1000, 32'd7, 32'd142, -1);

    // Reset between edges mid-divide clears outputs immediately.
    start_op(OP_DIV, 32'd77, 32'd5);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    check("midreset result", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("postreset no_done", 64'(done_seen), 64'd0);
    do_op("postreset op", OP_REM, 32'd77, 32'd5, 32'd2, -1);

    // Randomized operations with periodic special operands.
    for (int i = 0; i < 40; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = OP_MUL | 5'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'h8000_0000;
        default: ;
      endcase
      do_op($sformatf("rand%0d op=%0h a=%0h b=%0h", i, op, a, b), op, a, b,
            ref_model(op, a, b), -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
